cpu_program_sequencer: RTL and testbench



---
 rtl/cpu_program_sequencer_if.sv | 46 ++++
 rtl/cpu_program_sequencer.sv | 146 ++++++++++++++
 tb/tb_cpu_program_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_program_sequencer_if.sv
// Host/datapath bundle for the program sequencer: program load, run control, issue handshake and status.
// No logic of its own; master is the host/datapath side, slave is the sequencer.
// Define SEQ_BREAKPOINT_EN to add the bp_en/bp_addr/bp_hit signals.
interface cpu_program_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             prog_we;
  logic [3:0]       prog_addr;
  logic [11:0]      prog_wdata;
  logic             start;
  logic             stop;
  logic             acc_zero;
  logic             dp_ready;
  logic             dp_valid;
  logic [3:0]       dp_opcode;
  logic [3:0]       dp_addr;
  logic [3:0]       dp_data;
  logic [3:0]       pc;
  logic             busy;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] instr_count;
`ifdef SEQ_BREAKPOINT_EN
  logic             bp_en;
  logic [3:0]       bp_addr;
  logic             bp_hit;

  modport master (
    output prog_we, prog_addr, prog_wdata, start, stop, acc_zero, dp_ready, bp_en, bp_addr,
    input  dp_valid, dp_opcode, dp_addr, dp_data, pc, busy, halted, timeout_err, instr_count, bp_hit
  );
  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, stop, acc_zero, dp_ready, bp_en, bp_addr,
    output dp_valid, dp_opcode, dp_addr, dp_data, pc, busy, halted, timeout_err, instr_count, bp_hit
  );
`else
  modport master (
    output prog_we, prog_addr, prog_wdata, start, stop, acc_zero, dp_ready,
    input  dp_valid, dp_opcode, dp_addr, dp_data, pc, busy, halted, timeout_err, instr_count
  );
  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, stop, acc_zero, dp_ready,
    output dp_valid, dp_opcode, dp_addr, dp_data, pc, busy, halted, timeout_err, instr_count
  );
`endif
endinterface

// File: rtl/cpu_program_sequencer.sv
// Program controller: 16x12 program store, PC stepping, local JMP/JZ/NOP/HALT, datapath op issue.
// Latency: 2 cycles per instruction (FETCH + EXEC) with immediate dp_ready.
// Backpressure: dp_valid holds with stable fields until dp_ready; TIMEOUT_CYCLES stalled cycles abort to HALTED.
// Optional breakpoint logic is compiled in with SEQ_BREAKPOINT_EN.
module cpu_program_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input logic                    clk,
  input logic                    rst,
  cpu_program_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t           state_q, state_d;
  logic [11:0]      mem [16];
  logic [11:0]      ir_q;
  logic [3:0]       pc_q;
  logic [7:0]       wait_q;
  logic             timeout_q;
  logic             stop_pend_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0] ir_op, ir_addr;
  logic       exec_dp, hs, tmo_fire, halt_req, start_ok, retire, bp_fire;

  // Opcodes that go to the datapath; everything else is resolved here.
  function automatic logic is_dp(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: is_dp = 1'b1;
      default: is_dp = 1'b0;
    endcase
  endfunction

  assign ir_op    = ir_q[11:8];
  assign ir_addr  = ir_q[7:4];
  assign exec_dp  = (state_q == S_EXEC) && is_dp(ir_op);
  assign hs       = exec_dp && bus.dp_ready;
  assign tmo_fire = exec_dp && !bus.dp_ready && (wait_q == 8'(TIMEOUT_CYCLES - 1));
  // A stop seen earlier in EXEC (or together with start) is remembered until the next boundary.
  assign halt_req = bus.stop || stop_pend_q;
  assign start_ok = bus.start && ((state_q == S_IDLE) || (state_q == S_HALTED));
  assign retire   = (state_q == S_EXEC) && (is_dp(ir_op) ? bus.dp_ready : 1'b1);

`ifdef SEQ_BREAKPOINT_EN
  logic bp_hit_q, bp_skip_q;
  assign bp_fire = (state_q == S_FETCH) && bus.bp_en && (pc_q == bus.bp_addr) && !bp_skip_q;

  // Breakpoint flag, plus a one-shot skip so a resume can step past the breakpoint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      if (bp_fire)       bp_hit_q <= 1'b1;
      else if (start_ok) bp_hit_q <= 1'b0;
      if ((state_q == S_HALTED) && bus.start) bp_skip_q <= 1'b1;
      else if (state_q == S_FETCH)            bp_skip_q <= 1'b0;
    end
  end
  assign bus.bp_hit = bp_hit_q;
`else
  assign bp_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  state_d = (halt_req || bp_fire) ? S_HALTED : S_EXEC;
      S_EXEC: begin
        if (exec_dp) begin
          if (hs)            state_d = halt_req ? S_HALTED : S_FETCH;
          else if (tmo_fire) state_d = S_HALTED;
        end else begin
          state_d = (ir_op == OP_HALT) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: if (bus.start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs; dp_valid is decoded from state so reset drops it immediately.
  always_comb begin
    bus.dp_valid    = exec_dp;
    bus.dp_opcode   = ir_q[11:8];
    bus.dp_addr     = ir_q[7:4];
    bus.dp_data     = ir_q[3:0];
    bus.pc          = pc_q;
    bus.busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
    bus.halted      = (state_q == S_HALTED);
    bus.timeout_err = timeout_q;
    bus.instr_count = cnt_q;
  end

  // Program store: writable only while the sequencer is parked; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && ((state_q == S_IDLE) || (state_q == S_HALTED)))
      mem[bus.prog_addr] <= bus.prog_wdata;
  end

  // PC, instruction register, stall timer, error flag, stop latch and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      ir_q        <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start) pc_q <= '0;
        S_FETCH: if (state_d == S_EXEC) ir_q <= mem[pc_q];
        S_EXEC: begin
          if (retire) begin
            if (ir_op == OP_JMP)                    pc_q <= ir_addr;
            else if (ir_op == OP_JZ && bus.acc_zero) pc_q <= ir_addr;
            else                                     pc_q <= pc_q + 4'd1;
          end
        end
        default: ;
      endcase
      wait_q <= (exec_dp && !bus.dp_ready) ? wait_q + 8'd1 : 8'd0;
      if (tmo_fire)      timeout_q <= 1'b1;
      else if (start_ok) timeout_q <= 1'b0;
      if (state_d == S_HALTED)                        stop_pend_q <= 1'b0;
      else if ((start_ok || state_q == S_EXEC) && bus.stop) stop_pend_q <= 1'b1;
      if (retire && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Self-checking bench for cpu_program_sequencer: directed scenarios plus random programs
// checked against an instruction-level interpreter of the program store.
// Breakpoint scenario is included when SEQ_BREAKPOINT_EN is defined.
module tb_cpu_program_sequencer;
  localparam int CNT_W = 5;
  localparam int TMO   = 15;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  cpu_program_sequencer_if #(.CNT_W(CNT_W)) bus ();
  cpu_program_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt;
  logic [11:0] prog [16];
  logic [15:0] iss_q[$];
  logic [15:0] exp_q[$];
  logic [3:0] dp_ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
  logic [3:0] nop_ops [3] = '{4'h4, 4'hB, 4'hE};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_wdata = 0;
    bus.start = 0; bus.stop = 0; bus.acc_zero = 0; bus.dp_ready = 0;
`ifdef SEQ_BREAKPOINT_EN
    bus.bp_en = 0; bus.bp_addr = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic fill_halt;
    for (int i = 0; i < 16; i++) prog[i] = 12'hF00;
  endtask

  task automatic load_prog;
    for (int i = 0; i < 16; i++) begin
      bus.prog_we = 1; bus.prog_addr = 4'(i); bus.prog_wdata = prog[i];
      @(posedge clk); #1;
    end
    bus.prog_we = 0;
  endtask

  task automatic pulse_start;
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
  endtask

  // Runs until halted (bounded), logging every handshake as {pc, instruction}.
  // rdy_pct: 100 = always ready, 0 = never ready, else random with bounded low runs.
  task automatic run_to_halt(input int budget, input int rdy_pct, input bit noise, output int cycles);
    int lows;
    lows = 0;
    cycles = 0;
    iss_q.delete();
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.halted) return;
      if (bus.dp_valid && bus.dp_ready)
        iss_q.push_back({bus.pc, bus.dp_opcode, bus.dp_addr, bus.dp_data});
      @(posedge clk); #1;
      cycles++;
      if (rdy_pct >= 100)    bus.dp_ready = 1;
      else if (rdy_pct <= 0) bus.dp_ready = 0;
      else if (lows >= 4)    bus.dp_ready = 1;
      else                   bus.dp_ready = ($urandom_range(0, 99) < rdy_pct);
      lows = bus.dp_ready ? 0 : lows + 1;
      if (noise && !bus.halted) begin
        bus.start = ($urandom_range(0, 5) == 0);
        bus.prog_we = ($urandom_range(0, 3) == 0);
        bus.prog_addr = 4'($urandom_range(0, 15));
        bus.prog_wdata = 12'($urandom_range(0, 4095));
      end else begin
        bus.start = 0;
        bus.prog_we = 0;
      end
    end
    bus.start = 0; bus.prog_we = 0;
    chk("halt_within_budget", bus.halted, 1);
  endtask

  // Instruction-level interpreter of the program; fills exp_q with expected datapath issues.
  task automatic model_run(input logic [3:0] start_pc, input bit az,
                           output bit ok, output logic [3:0] fpc, output int nret);
    logic [3:0] p, op;
    logic [11:0] ins;
    p = start_pc; ok = 0; nret = 0;
    exp_q.delete();
    for (int s = 0; s < 60 && !ok; s++) begin
      ins = prog[p]; op = ins[11:8]; nret++;
      if (op == 4'hC)      p = ins[7:4];
      else if (op == 4'hD) p = az ? ins[7:4] : p + 4'd1;
      else if (op == 4'hF) begin p = p + 4'd1; ok = 1; end
      else if (op == 4'h4 || op == 4'hB || op == 4'hE) p = p + 4'd1;
      else begin exp_q.push_back({p, ins}); p = p + 4'd1; end
    end
    fpc = p;
  endtask

  initial begin
    int cyc, vcnt, nret, sel;
    bit found, ok, az;
    logic [3:0] fpc, cur_pc, op;

    // Reset state
    do_reset;
    @(negedge clk);
    chk("rst_dp_valid", bus.dp_valid, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    chk("rst_count", bus.instr_count, 0);
    chk("rst_dp_fields", {bus.dp_opcode, bus.dp_addr, bus.dp_data}, 0);

    // LOAD, ADD, HALT with dp_ready tied high
    fill_halt;
    prog[0] = 12'h3A3; prog[1] = 12'h0D5; prog[2] = 12'hF00;
    load_prog;
    bus.dp_ready = 1;
    pulse_start;
    run_to_halt(50, 100, 0, cyc);
    chk("basic_cycles", cyc, 6);
    chk("basic_issued", iss_q.size(), 2);
    if (iss_q.size() == 2) begin
      chk("basic_issue0", iss_q[0], 16'h03A3);
      chk("basic_issue1", iss_q[1], 16'h10D5);
    end
    chk("basic_pc", bus.pc, 3);
    chk("basic_count", bus.instr_count, 3);

    // JZ taken and not taken
    for (int z = 0; z < 2; z++) begin
      do_reset;
      fill_halt;
      prog[0] = 12'h400; prog[1] = 12'hB00; prog[2] = 12'hE00; prog[3] = 12'h400;
      prog[4] = 12'hD90;
      load_prog;
      bus.acc_zero = (z == 0); bus.dp_ready = 1;
      pulse_start;
      run_to_halt(60, 100, 0, cyc);
      chk("jz_pc", bus.pc, (z == 0) ? 10 : 6);
      chk("jz_count", bus.instr_count, 6);
      chk("jz_issued", iss_q.size(), 0);
    end

    // ADD stalled for 3 cycles
    do_reset;
    fill_halt;
    prog[0] = 12'h0B7;
    load_prog;
    bus.dp_ready = 0;
    pulse_start;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (bus.dp_valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("stall_valid_seen", found, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; @(negedge clk); end
      chk("stall_valid", bus.dp_valid, 1);
      chk("stall_fields", {bus.dp_opcode, bus.dp_addr, bus.dp_data}, 12'h0B7);
      chk("stall_no_retire", bus.instr_count, 0);
    end
    @(posedge clk); #1;
    bus.dp_ready = 1;
    @(negedge clk);
    chk("hs_valid", bus.dp_valid, 1);
    chk("hs_count_before", bus.instr_count, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_count_after", bus.instr_count, 1);
    chk("hs_valid_drop", bus.dp_valid, 0);
    chk("hs_pc", bus.pc, 1);
    run_to_halt(40, 100, 0, cyc);
    chk("stall_end_pc", bus.pc, 2);
    chk("stall_end_count", bus.instr_count, 2);

    // Timeout with dp_ready stuck low
    do_reset;
    fill_halt;
    prog[0] = 12'h1C4;
    load_prog;
    bus.dp_ready = 0;
    pulse_start;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.halted) break;
      if (bus.dp_valid) vcnt++;
      @(posedge clk); #1;
    end
    chk("tmo_valid_cycles", vcnt, TMO);
    chk("tmo_halted", bus.halted, 1);
    chk("tmo_err", bus.timeout_err, 1);
    chk("tmo_valid_low", bus.dp_valid, 0);
    chk("tmo_pc", bus.pc, 0);
    chk("tmo_count", bus.instr_count, 0);
    bus.dp_ready = 1;
    pulse_start;
    @(negedge clk);
    chk("tmo_err_cleared", bus.timeout_err, 0);
    run_to_halt(40, 100, 0, cyc);
    chk("tmo_resume_issued", iss_q.size(), 1);
    chk("tmo_resume_pc", bus.pc, 2);
    chk("tmo_resume_count", bus.instr_count, 2);

    // JMP self-loop at 15, writes ignored while busy, stop and start+stop
    do_reset;
    fill_halt;
    prog[0] = 12'hCF0; prog[15] = 12'hCF0;
    load_prog;
    pulse_start;
    for (int k = 0; k < 10; k++) begin
      bus.prog_we = 1; bus.prog_addr = 4'hF; bus.prog_wdata = 12'hF00;
      @(posedge clk); #1;
    end
    bus.prog_we = 0;
    @(negedge clk);
    chk("loop_busy", bus.busy, 1);
    chk("loop_pc", bus.pc, 15);
    @(posedge clk); #1;
    bus.stop = 1;
    @(posedge clk); #1;
    bus.stop = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("loop_stop_halted", bus.halted, 1);
    chk("loop_stop_pc", bus.pc, 15);
    pulse_start;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("loop_mem_kept", bus.halted, 0);
    chk("loop_resume_pc", bus.pc, 15);
    @(posedge clk); #1;
    bus.stop = 1;
    @(posedge clk); #1;
    bus.stop = 0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1; bus.stop = 1;
    @(posedge clk); #1;
    bus.start = 0; bus.stop = 0;
    @(negedge clk);
    chk("startstop_busy", bus.busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("startstop_halted", bus.halted, 1);
    chk("startstop_pc", bus.pc, 15);

`ifdef SEQ_BREAKPOINT_EN
    // Breakpoint at pc 2, then step past it
    do_reset;
    fill_halt;
    prog[0] = 12'h3A3; prog[1] = 12'h0D5; prog[2] = 12'h712; prog[3] = 12'hF00;
    load_prog;
    bus.bp_en = 1; bus.bp_addr = 4'd2; bus.dp_ready = 1;
    pulse_start;
    run_to_halt(40, 100, 0, cyc);
    chk("bp_pc", bus.pc, 2);
    chk("bp_hit", bus.bp_hit, 1);
    chk("bp_issued", iss_q.size(), 2);
    pulse_start;
    @(negedge clk);
    chk("bp_hit_cleared", bus.bp_hit, 0);
    run_to_halt(40, 100, 0, cyc);
    chk("bp_step_issued", iss_q.size(), 1);
    if (iss_q.size() == 1) chk("bp_step_issue", iss_q[0], 16'h2712);
    chk("bp_end_pc", bus.pc, 4);
    chk("bp_end_count", bus.instr_count, 4);
`endif

    // Random programs against the interpreter, resuming from wherever the last run halted
    do_reset;
    cur_pc = 0;
    for (int r = 0; r < 25; r++) begin
      az = 1'($urandom_range(0, 1));
      ok = 0;
      for (int a = 0; a < 50 && !ok; a++) begin
        for (int i = 0; i < 16; i++) begin
          sel = $urandom_range(0, 15);
          if (sel < 9)       op = dp_ops[$urandom_range(0, 9)];
          else if (sel < 11) op = 4'hC;
          else if (sel < 13) op = 4'hD;
          else if (sel < 15) op = 4'hF;
          else               op = nop_ops[$urandom_range(0, 2)];
          prog[i] = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        end
        model_run(cur_pc, az, ok, fpc, nret);
      end
      if (!ok) begin
        fill_halt;
        model_run(cur_pc, az, ok, fpc, nret);
      end
      load_prog;
      bus.acc_zero = az;
      bus.dp_ready = 1'($urandom_range(0, 1));
      pulse_start;
      run_to_halt(600, 70, 1, cyc);
      exp_cnt = sat(exp_cnt + nret);
      chk("rnd_issued", iss_q.size(), exp_q.size());
      for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++)
        chk("rnd_issue", iss_q[i], exp_q[i]);
      chk("rnd_pc", bus.pc, fpc);
      chk("rnd_count", bus.instr_count, exp_cnt);
      chk("rnd_timeout", bus.timeout_err, 0);
      cur_pc = fpc;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
